// File: rtl/bsg_chip_dma_arbiter_if.sv
// Bundle of requester-side and DRAM-side DMA signals shared by the two-to-one DMA arbiter.
// The arbiter connects through modport master; the environment drives the slave side.
interface bsg_chip_dma_arbiter_if #(
    parameter int daddr_width_p = 40,
    parameter int data_width_p  = 64
);
    localparam int pkt_w = daddr_width_p + 1;

    logic [1:0][pkt_w-1:0]        req_pkt_i;
    logic [1:0]                   req_pkt_v_i;
    logic [1:0]                   req_pkt_yumi_o;
    logic [data_width_p-1:0]      req_rdata_o;
    logic [1:0]                   req_rdata_v_o;
    logic [1:0]                   req_rdata_ready_and_i;
    logic [1:0][data_width_p-1:0] req_wdata_i;
    logic [1:0]                   req_wdata_v_i;
    logic [1:0]                   req_wdata_yumi_o;

    logic [pkt_w-1:0]             dma_pkt_o;
    logic                         dma_pkt_v_o;
    logic                         dma_pkt_yumi_i;
    logic [data_width_p-1:0]      dma_data_i;
    logic                         dma_data_v_i;
    logic                         dma_data_ready_and_o;
    logic [data_width_p-1:0]      dma_data_o;
    logic                         dma_data_v_o;
    logic                         dma_data_yumi_i;

    modport master (
        input  req_pkt_i, req_pkt_v_i, req_rdata_ready_and_i, req_wdata_i, req_wdata_v_i,
               dma_pkt_yumi_i, dma_data_i, dma_data_v_i, dma_data_yumi_i,
        output req_pkt_yumi_o, req_rdata_o, req_rdata_v_o, req_wdata_yumi_o,
               dma_pkt_o, dma_pkt_v_o, dma_data_ready_and_o, dma_data_o, dma_data_v_o
    );

    modport slave (
        output req_pkt_i, req_pkt_v_i, req_rdata_ready_and_i, req_wdata_i, req_wdata_v_i,
               dma_pkt_yumi_i, dma_data_i, dma_data_v_i, dma_data_yumi_i,
        input  req_pkt_yumi_o, req_rdata_o, req_rdata_v_o, req_wdata_yumi_o,
               dma_pkt_o, dma_pkt_v_o, dma_data_ready_and_o, dma_data_o, dma_data_v_o
    );
endinterface

// File: rtl/bsg_chip_dma_arbiter.sv
// Two-to-one DMA arbiter: round-robin packet grant, order FIFOs steer read/write beats.
// Define BSG_CHIP_DMA_ARB_FIXED_PRIO_EN to make requester 0 always win when eligible.
module bsg_chip_dma_arbiter #(
    parameter int daddr_width_p = 40,
    parameter int data_width_p  = 64,
    parameter int fill_beats_p  = 8,
    parameter int tag_els_p     = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    bsg_chip_dma_arbiter_if.master bus
);
    localparam int pkt_w  = daddr_width_p + 1;
    localparam int ptr_w  = (tag_els_p > 1) ? $clog2(tag_els_p) : 1;
    localparam int cnt_w  = $clog2(tag_els_p + 1);
    localparam int beat_w = (fill_beats_p > 1) ? $clog2(fill_beats_p) : 1;

    logic       lock_reg;
    logic       g_reg;
    logic       winner;
    logic [1:0] elig;
    logic       pkt_hs;
    logic       pkt_is_wr;
    logic       granted_v;

    // Index 0 is the read-order FIFO, index 1 the write-order FIFO.
    logic [1:0] fifo_push;
    logic [1:0] fifo_pop;
    logic [1:0] fifo_head;
    logic [1:0] fifo_ne;
    logic [1:0] fifo_full;
    logic [1:0] beat_hs;

    genvar gi;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_order
            logic             mem_reg [tag_els_p];
            logic [ptr_w-1:0] wptr_reg;
            logic [ptr_w-1:0] rptr_reg;
            logic [cnt_w-1:0] count_reg;
            logic [beat_w-1:0] beat_cnt_reg;
            logic             last_beat;

            always_ff @(posedge clk_i) begin
                if (fifo_push[gi]) begin
                    mem_reg[wptr_reg] <= g_reg;
                end
            end

            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    wptr_reg  <= '0;
                    rptr_reg  <= '0;
                    count_reg <= '0;
                end else begin
                    if (fifo_push[gi]) begin
                        wptr_reg <= (wptr_reg == ptr_w'(tag_els_p - 1)) ? '0 : wptr_reg + ptr_w'(1);
                    end
                    if (fifo_pop[gi]) begin
                        rptr_reg <= (rptr_reg == ptr_w'(tag_els_p - 1)) ? '0 : rptr_reg + ptr_w'(1);
                    end
                    if (fifo_push[gi] && !fifo_pop[gi]) begin
                        count_reg <= count_reg + cnt_w'(1);
                    end else if (!fifo_push[gi] && fifo_pop[gi]) begin
                        count_reg <= count_reg - cnt_w'(1);
                    end
                end
            end

            assign last_beat = (beat_cnt_reg == beat_w'(fill_beats_p - 1));

            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    beat_cnt_reg <= '0;
                end else if (beat_hs[gi]) begin
                    beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + beat_w'(1);
                end
            end

            assign fifo_head[gi] = mem_reg[rptr_reg];
            assign fifo_ne[gi]   = (count_reg != '0);
            assign fifo_full[gi] = (count_reg == cnt_w'(tag_els_p));
            assign fifo_pop[gi]  = beat_hs[gi] & last_beat;
        end

        // Eligibility uses registered occupancy, so a same-cycle pop does not free a slot.
        for (gi = 0; gi < 2; gi++) begin : g_elig
            assign elig[gi] = bus.req_pkt_v_i[gi] & ~fifo_full[bus.req_pkt_i[gi][pkt_w-1]];
        end
    endgenerate

`ifdef BSG_CHIP_DMA_ARB_FIXED_PRIO_EN
    assign winner = elig[0] ? 1'b0 : 1'b1;
`else
    logic last_g_reg;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_g_reg <= 1'b1;
        end else if (pkt_hs) begin
            last_g_reg <= g_reg;
        end
    end

    assign winner = last_g_reg ? (elig[0] ? 1'b0 : 1'b1)
                               : (elig[1] ? 1'b1 : 1'b0);
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lock_reg <= 1'b0;
            g_reg    <= 1'b0;
        end else if (lock_reg) begin
            if (bus.dma_pkt_yumi_i) begin
                lock_reg <= 1'b0;
            end
        end else if (|elig) begin
            lock_reg <= 1'b1;
            g_reg    <= winner;
        end
    end

    assign pkt_hs       = lock_reg & bus.dma_pkt_yumi_i;
    assign pkt_is_wr    = bus.req_pkt_i[g_reg][pkt_w-1];
    assign fifo_push[0] = pkt_hs & ~pkt_is_wr;
    assign fifo_push[1] = pkt_hs &  pkt_is_wr;

    assign bus.dma_pkt_v_o    = lock_reg;
    assign bus.dma_pkt_o      = lock_reg ? bus.req_pkt_i[g_reg] : '0;
    assign bus.req_pkt_yumi_o = pkt_hs ? (2'b01 << g_reg) : 2'b00;

    assign bus.req_rdata_o          = bus.dma_data_i;
    assign bus.dma_data_ready_and_o = fifo_ne[0] & bus.req_rdata_ready_and_i[fifo_head[0]];
    assign bus.req_rdata_v_o        = (bus.dma_data_v_i & fifo_ne[0]) ? (2'b01 << fifo_head[0]) : 2'b00;
    assign beat_hs[0]               = bus.dma_data_v_i & bus.dma_data_ready_and_o;

    assign bus.dma_data_v_o     = fifo_ne[1] & bus.req_wdata_v_i[fifo_head[1]];
    assign bus.dma_data_o       = bus.req_wdata_i[fifo_head[1]];
    assign beat_hs[1]           = bus.dma_data_v_o & bus.dma_data_yumi_i;
    assign bus.req_wdata_yumi_o = beat_hs[1] ? (2'b01 << fifo_head[1]) : 2'b00;

    // Requesters must hold their packet until it is consumed.
    assign granted_v = bus.req_pkt_v_i[g_reg];
    assert property (@(posedge clk_i) disable iff (reset_i) lock_reg |-> granted_v);
endmodule

// File: doc/bsg_chip_dma_arbiter.md
# bsg_chip_dma_arbiter

Two-to-one arbiter that shares the chip's single DRAM DMA channel (bsg_cache DMA packet, fill-data in, fill-data out) between two DMA requesters, for example two L2 cache slices. It sits between the requesters and the DRAM interface of bsg_chip. It arbitrates packets round-robin, records the order of accepted reads and writes, and steers each read-return and write-data beat to or from the correct requester.

## Interface
- daddr_width_p, 40, DMA address width; packet width is pkt_w = daddr_width_p+1, with {write_not_read, addr} and write_not_read as the MSB
- data_width_p, 64, fill data width (equals l2_fill_width_p)
- fill_beats_p, 8, data beats per DMA packet, must be ≥1
- tag_els_p, 4, depth of each read and write order FIFO, must be ≥2

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- req_pkt_i  in  2×pkt_w  per-requester DMA packet
- req_pkt_v_i  in  2  packet valid; must hold until yumi
- req_pkt_yumi_o  out  2  packet consumed
- req_rdata_o  out  data_width_p  read data broadcast to both requesters
- req_rdata_v_o  out  2  read beat valid, one-hot
- req_rdata_ready_and_i  in  2  requester can accept a read beat
- req_wdata_i  in  2×data_width_p  write data
- req_wdata_v_i  in  2  write data valid
- req_wdata_yumi_o  out  2  write beat consumed
- dma_pkt_o  out  pkt_w  packet to DRAM
- dma_pkt_v_o  out  1  packet valid
- dma_pkt_yumi_i  in  1  DRAM consumed packet
- dma_data_i  in  data_width_p  read return data
- dma_data_v_i  in  1  read beat valid
- dma_data_ready_and_o  out  1  arbiter accepts read beat
- dma_data_o  out  data_width_p  write data to DRAM
- dma_data_v_o  out  1  write beat valid
- dma_data_yumi_i  in  1  DRAM consumed write beat

## Operation
- **Grant register g (1 bit) with lock bit.**
  - While unlocked, choose the winner among eligible requesters, round-robin starting after last_g.
  - A requester is eligible when req_pkt_v_i is high and the FIFO for its packet type (selected by the write_not_read bit) has space.
  - When a winner exists, set lock and g = winner.
  - While locked: dma_pkt_v_o=1 and dma_pkt_o=req_pkt_i[g].
  - On dma_pkt_yumi_i: req_pkt_yumi_o[g]=1, push g into the rd FIFO or wr FIFO, set last_g=g, clear lock.
- **Read steering.** h = rd FIFO head.
  - dma_data_ready_and_o = rd FIFO nonempty & req_rdata_ready_and_i[h].
  - req_rdata_v_o[h] = dma_data_v_i & rd FIFO nonempty.
  - req_rdata_o = dma_data_i.
  - Each handshake increments rd_cnt. On beat fill_beats_p-1, rd_cnt wraps to 0 and the FIFO pops.
- **Write steering.** w = wr FIFO head.
  - dma_data_v_o = wr FIFO nonempty & req_wdata_v_i[w].
  - dma_data_o = req_wdata_i[w].
  - req_wdata_yumi_o[w] = dma_data_yumi_i.
  - wr_cnt wraps and pops exactly as the read side does.
- **Empty FIFO.** The corresponding ready or valid outputs are 0, and stray dma_data_v_i is not accepted.
- **Full FIFO.** Packets of that type are ineligible. The other type is still arbitrated.

## Timing
- Reset values:
  - lock=0, last_g=1 (so requester 0 wins first), FIFOs empty, counters 0.
  - Every output valid, yumi and ready is 0.
- Packet path latency:
  - From req_pkt_v_i rising to dma_pkt_v_o: 1 cycle (lock is registered).
  - Back-to-back packets need one unlocked cycle each, so the maximum is one packet per 2 cycles.
- A FIFO push is visible at its head the cycle after dma_pkt_yumi_i.
  - Write data for a packet can therefore start the cycle after packet acceptance, with no bypass.
  - Read data behaves the same way.
- Space checks use registered FIFO occupancy. A pop in the same cycle does not free space for that cycle's grant decision.
- A push and a pop in the same cycle on one FIFO are legal; occupancy is unchanged.
- Read and write data paths run concurrently and independently of packet arbitration.
- Once locked, the grant never changes, even if req_pkt_v_i drops (that is a protocol violation; flagged by an assertion).
- Reset asserted mid-transfer discards all state on the next edge. Outputs are 0 the cycle after reset is sampled.

## Configuration
- BSG_CHIP_DMA_ARB_FIXED_PRIO_EN
  - Defined: requester 0 always wins when eligible; last_g is unused.
  - Undefined: round-robin as above.

## Test plan
- Reset, then req 0 read at addr 0x100 → dma_pkt_o={0,0x100} one cycle later. After yumi, 8 beats 0..7 on dma_data_i appear only on req_rdata_v_o[0].
- Both requesters post reads continuously, DRAM yumi always high → grants alternate 0,1,0,1. Read data returns in grant order, 8 beats each, with no misrouting.
- Req 1 write to 0x200 while req 0 reads → write beats come from req_wdata_i[1] only, starting the cycle after pkt yumi. Read beats go to req 0, and both flows overlap.
- Fill the rd FIFO with 4 reads and withhold data → a 5th read is not granted, but a write from the other requester is granted. After the first 8 read beats, the 5th read is granted.
- req_rdata_ready_and_i[0]=0 mid-burst at beat 3 → dma_data_ready_and_o=0 and the counter holds. Resuming completes beats 3–7.
- Assert reset after 4 of 8 read beats → all outputs 0 and FIFOs empty. A new read starts at beat 0.
